// File: rtl/md_pkg.sv
// md_pkg: shared constants, op codes and FSM state type for the
// multiply/divide unit. Optional feature macro: MD_MADD_EN (MADD/MSUB).
package md_pkg;

    localparam int MD_W  = 32;
    localparam int MD_DW = 64;

    localparam logic [3:0] MD_MULT  = 4'b0000;
    localparam logic [3:0] MD_MULTU = 4'b0001;
    localparam logic [3:0] MD_DIV   = 4'b0010;
    localparam logic [3:0] MD_DIVU  = 4'b0011;
    localparam logic [3:0] MD_MTHI  = 4'b0100;
    localparam logic [3:0] MD_MTLO  = 4'b0101;
    localparam logic [3:0] MD_MADD  = 4'b0110;
    localparam logic [3:0] MD_MSUB  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DIV_FIX = 2'd3
    } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// md_div_core: 32-iteration unsigned restoring divider. A load captures the
// operands, each step retires one quotient bit, done flags the final step.
module md_div_core
    import md_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [MD_W-1:0]  dividend,
    input  logic [MD_W-1:0]  divisor,
    output logic             done,
    output logic [MD_W-1:0]  quotient,
    output logic [MD_W-1:0]  remainder
);

    logic [MD_DW-1:0] rq_r;
    logic [MD_W-1:0]  dvs_r;
    logic [4:0]       cnt_r;
    logic [MD_DW:0]   shift_s;
    logic [MD_W:0]    diff_s;
    logic [MD_DW-1:0] rq_next_s;

    // One restoring step: shift left, trial-subtract, keep on non-negative.
    always_comb begin
        shift_s   = {rq_r, 1'b0};
        diff_s    = shift_s[MD_DW:MD_W] - {1'b0, dvs_r};
        rq_next_s = shift_s[MD_DW-1:0];
        if (diff_s[MD_W] == 1'b0) begin
            rq_next_s = {diff_s[MD_W-1:0], shift_s[MD_W-1:1], 1'b1};
        end else begin
            rq_next_s = shift_s[MD_DW-1:0];
        end
    end

    // Remainder/quotient shift register, divisor latch and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_r  <= 64'd0;
            dvs_r <= 32'd0;
            cnt_r <= 5'd0;
        end else if (load) begin
            rq_r  <= {32'd0, dividend};
            dvs_r <= divisor;
            cnt_r <= 5'd0;
        end else if (step) begin
            rq_r  <= rq_next_s;
            cnt_r <= cnt_r + 5'd1;
        end else begin
            rq_r  <= rq_r;
            cnt_r <= cnt_r;
        end
    end

    assign done      = step && (cnt_r == 5'd31);
    assign quotient  = rq_r[MD_W-1:0];
    assign remainder = rq_r[MD_DW-1:MD_W];

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO, the control FSM, the
// multiply latency counter and divide sign handling. Optional feature macro:
// MD_MADD_EN adds MADD/MSUB accumulating into {hi,lo}.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [MD_W-1:0]  A,
    input  logic [MD_W-1:0]  B,
    output logic             busy,
    output logic [MD_W-1:0]  hi,
    output logic [MD_W-1:0]  lo
);

    localparam logic [3:0] MUL_INIT = 4'(MULT_LAT - 1);

    md_state_e        state_r, state_s;
    logic             busy_r;
    logic [MD_W-1:0]  hi_r, lo_r;
    logic [MD_DW-1:0] stage_r;
    logic [3:0]       mul_cnt_r;
    logic             neg_q_r, neg_r_r, div0_r;

    logic             accept_s, is_mul_s, mul_signed_s, div_signed_s;
    logic             div_load_s, div_step_s, div_done_s;
    logic [MD_DW-1:0] a_ext_s, b_ext_s, prod_s, stage_in_s, mul_res_s;
    logic [MD_W-1:0]  a_abs_s, b_abs_s, div_q_s, div_r_s, quo_s, rem_s;

`ifdef MD_MADD_EN
    logic             acc_r;
`endif

    assign accept_s = start && (state_r == ST_IDLE);

    // Op decode: which ops take the multiply path and which are signed.
    always_comb begin
        is_mul_s     = 1'b0;
        mul_signed_s = 1'b0;
        div_signed_s = 1'b0;
        case (op)
            MD_MULT:  begin is_mul_s = 1'b1; mul_signed_s = 1'b1; end
            MD_MULTU: begin is_mul_s = 1'b1; mul_signed_s = 1'b0; end
`ifdef MD_MADD_EN
            MD_MADD,
            MD_MSUB:  begin is_mul_s = 1'b1; mul_signed_s = 1'b1; end
`endif
            MD_DIV:   div_signed_s = 1'b1;
            default:  begin is_mul_s = 1'b0; mul_signed_s = 1'b0; end
        endcase
    end

    // State register; busy is kept as a register tracking state != IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && is_mul_s) begin
                    state_s = ST_MUL;
                end else if (start && (op == MD_DIV || op == MD_DIVU)) begin
                    state_s = (B == 32'd0) ? ST_DIV_FIX : ST_DIV_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL:     state_s = (mul_cnt_r == 4'd0) ? ST_IDLE : ST_MUL;
            ST_DIV_RUN: state_s = div_done_s ? ST_DIV_FIX : ST_DIV_RUN;
            ST_DIV_FIX: state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Datapath outputs of the FSM: product, operand magnitudes, signed fixup.
    always_comb begin
        a_ext_s    = mul_signed_s ? {{32{A[31]}}, A} : {32'd0, A};
        b_ext_s    = mul_signed_s ? {{32{B[31]}}, B} : {32'd0, B};
        prod_s     = a_ext_s * b_ext_s;
        stage_in_s = prod_s;
`ifdef MD_MADD_EN
        if (op == MD_MSUB) begin
            stage_in_s = 64'd0 - prod_s;
        end else begin
            stage_in_s = prod_s;
        end
        mul_res_s  = acc_r ? ({hi_r, lo_r} + stage_r) : stage_r;
`else
        mul_res_s  = stage_r;
`endif
        if (div_signed_s && A[31]) begin
            a_abs_s = 32'd0 - A;
        end else begin
            a_abs_s = A;
        end
        if (div_signed_s && B[31]) begin
            b_abs_s = 32'd0 - B;
        end else begin
            b_abs_s = B;
        end
        div_load_s = accept_s && (op == MD_DIV || op == MD_DIVU) && (B != 32'd0);
        div_step_s = (state_r == ST_DIV_RUN);
        quo_s      = neg_q_r ? (32'd0 - div_q_s) : div_q_s;
        rem_s      = neg_r_r ? (32'd0 - div_r_s) : div_r_s;
    end

    md_div_core u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load_s),
        .step      (div_step_s),
        .dividend  (a_abs_s),
        .divisor   (b_abs_s),
        .done      (div_done_s),
        .quotient  (div_q_s),
        .remainder (div_r_s)
    );

    // Operand capture at accept, MUL countdown, and HI/LO write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            stage_r   <= 64'd0;
            mul_cnt_r <= 4'd0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            div0_r    <= 1'b0;
`ifdef MD_MADD_EN
            acc_r     <= 1'b0;
`endif
        end else if (accept_s) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    stage_r   <= stage_in_s;
                    mul_cnt_r <= MUL_INIT;
`ifdef MD_MADD_EN
                    acc_r     <= 1'b0;
`endif
                end
`ifdef MD_MADD_EN
                MD_MADD, MD_MSUB: begin
                    stage_r   <= stage_in_s;
                    mul_cnt_r <= MUL_INIT;
                    acc_r     <= 1'b1;
                end
`endif
                MD_DIV, MD_DIVU: begin
                    neg_q_r <= div_signed_s && (A[31] ^ B[31]);
                    neg_r_r <= div_signed_s && A[31];
                    div0_r  <= (B == 32'd0);
                end
                MD_MTHI: hi_r <= A;
                MD_MTLO: lo_r <= A;
                default: hi_r <= hi_r;
            endcase
        end else begin
            case (state_r)
                ST_MUL: begin
                    if (mul_cnt_r == 4'd0) begin
                        {hi_r, lo_r} <= mul_res_s;
                    end else begin
                        mul_cnt_r <= mul_cnt_r - 4'd1;
                    end
                end
                ST_DIV_FIX: begin
                    if (!div0_r) begin
                        lo_r <= quo_s;
                        hi_r <= rem_s;
                    end else begin
                        lo_r <= lo_r;
                    end
                end
                default: hi_r <= hi_r;
            endcase
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plus randomized stimulus against an arithmetic
// reference model of HI/LO and of the expected busy duration.
module tb_md_unit;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS semantics computed with wide integer arithmetic.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nb);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        nb = 0;
        case (o)
            4'd0: begin p = sa * sb; {m_hi, m_lo} = p; nb = LAT; end
            4'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; nb = LAT; end
            4'd2: begin
                if (b != 32'd0) begin
                    p = sa / sb; m_lo = p[31:0];
                    p = sa % sb; m_hi = p[31:0];
                    nb = 33;
                end else nb = 1;
            end
            4'd3: begin
                if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; nb = 33; end
                else nb = 1;
            end
            4'd4: m_hi = a;
            4'd5: m_lo = a;
`ifdef MD_MADD_EN
            4'd6: begin p = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = p; nb = LAT; end
            4'd7: begin p = {m_hi, m_lo} - 64'(sa * sb); {m_hi, m_lo} = p; nb = LAT; end
`endif
            default: nb = 0;
        endcase
    endtask

    // Called at a negedge with busy low; returns at the first negedge with busy low.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int nb, exp_nb;
        model(o, a, b, exp_nb);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk($sformatf("busy_len op%0d", o), 64'(nb), 64'(exp_nb));
        chk($sformatf("hi op%0d", o), {32'd0, hi}, {32'd0, m_hi});
        chk($sformatf("lo op%0d", o), {32'd0, lo}, {32'd0, m_lo});
    endtask

    initial begin
        int          nb;
        logic [31:0] ra, rb;
        logic [3:0]  ro;

        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd0, 32'hFFFFFFFF, 32'd3);
        chk("mult_hi_const", {32'd0, hi}, 64'hFFFFFFFF);
        chk("mult_lo_const", {32'd0, lo}, 64'hFFFFFFFD);
        run_op(4'd1, 32'hFFFFFFFF, 32'd2);
        chk("multu_hi_const", {32'd0, hi}, 64'h1);
        run_op(4'd2, 32'hFFFFFFF9, 32'd2);
        chk("div_lo_const", {32'd0, lo}, 64'hFFFFFFFD);
        chk("div_hi_const", {32'd0, hi}, 64'hFFFFFFFF);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2);
        chk("divu_lo_const", {32'd0, lo}, 64'h7FFFFFFC);
        run_op(4'd4, 32'h1234, 32'd0);
        run_op(4'd2, 32'd99, 32'd0);
        chk("div0_hi_const", {32'd0, hi}, 64'h1234);
        run_op(4'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo", {32'd0, lo}, 64'h80000000);
        chk("div_ovf_hi", {32'd0, hi}, 64'h0);
        run_op(4'd9, 32'hDEAD, 32'hBEEF);

        // MTLO issued while a divide is in flight must be dropped.
        model(4'd2, 32'd100, 32'd7, nb);
        start = 1'b1; op = 4'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 4'd5; A = 32'hAA;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin nb++; @(negedge clk); end
        chk("ignored_busy_rest", 64'(nb), 64'd29);
        chk("ignored_lo", {32'd0, lo}, {32'd0, m_lo});
        chk("ignored_hi", {32'd0, hi}, {32'd0, m_hi});

        // Asynchronous reset in the middle of DIV_RUN.
        start = 1'b1; op = 4'd3; A = 32'd12345; B = 32'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef MD_MADD_EN
        run_op(4'd4, 32'd0, 32'd0);
        run_op(4'd5, 32'd10, 32'd0);
        run_op(4'd6, 32'd3, 32'd4);
        chk("madd_lo_const", {32'd0, lo}, 64'd22);
        run_op(4'd7, 32'd5, 32'd5);
        chk("msub_lo_const", {32'd0, lo}, 64'hFFFFFFFD);
        chk("msub_hi_const", {32'd0, hi}, 64'hFFFFFFFF);
`endif

        for (int i = 0; i < 80; i++) begin
            ro = 4'($urandom_range(0, 9));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ra = ra;
            endcase
            run_op(ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
